// File: rtl/voice_allocator.sv
// Polyphony voice allocator: maps serial note-on/note-off commands onto
// NUM_VOICES slots with LRU ranking, release-tail countdown and voice stealing.
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int IDX_W      = $clog2(NUM_VOICES),
  parameter int REL_W      = 16
) (
  input  logic                    AUD_BCLK,
  input  logic                    AUD_DACLRCK,
  input  logic                    sample_tick,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_play,
  input  logic [6:0]              cmd_pitch,
  input  logic [REL_W-1:0]        release_len,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_busy,
  output logic [7*NUM_VOICES-1:0] voice_pitch,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    steal_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} ctrl_t;
  typedef enum logic [1:0] {V_FREE, V_ACTIVE, V_REL} vstate_t;

  ctrl_t r_state, w_stateNext;

  vstate_t          r_vState [NUM_VOICES];
  vstate_t          w_vStateNext [NUM_VOICES];
  logic [6:0]       r_vPitch [NUM_VOICES];
  logic [6:0]       w_vPitchNext [NUM_VOICES];
  logic [REL_W-1:0] r_vCnt [NUM_VOICES];
  logic [REL_W-1:0] w_vCntNext [NUM_VOICES];
  logic [IDX_W-1:0] r_vRank [NUM_VOICES];
  logic [IDX_W-1:0] w_vRankNext [NUM_VOICES];

  logic             r_play;
  logic [6:0]       r_pitch;
  logic [REL_W-1:0] r_relLen;

  logic [NUM_VOICES-1:0] w_matchMask, w_freeMask, w_relMask;
  logic [NUM_VOICES-1:0] r_matchMask, r_freeMask, r_relMask;
  logic [IDX_W-1:0]      w_matchIdx, w_freeIdx, w_relIdx, w_actIdx;
  logic [IDX_W-1:0]      r_matchIdx, r_freeIdx, r_relIdx, r_actIdx;
  logic [IDX_W-1:0]      w_relBest, w_actBest;
  logic                  w_relFound, w_actFound;

  logic [IDX_W-1:0]      w_target;
  logic                  w_stealCand;
  logic [NUM_VOICES-1:0] w_trigNext;
  logic                  w_stealNext;

  logic [NUM_VOICES-1:0] r_gate, r_busy, r_trig;
  logic                  r_steal;

  always_ff @(posedge AUD_BCLK or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) r_state <= S_IDLE;
    else             r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_stateNext = S_SEARCH;
      S_SEARCH: w_stateNext = S_COMMIT;
      S_COMMIT: w_stateNext = S_IDLE;
      default:  w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge AUD_BCLK or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      r_play   <= 1'b0;
      r_pitch  <= '0;
      r_relLen <= '0;
    end else if (cmd_ready && cmd_valid) begin
      r_play   <= cmd_play;
      r_pitch  <= cmd_pitch;
      r_relLen <= release_len;
    end
  end

  // Candidate search; ranks are unique so the oldest candidate is unambiguous.
  always_comb begin
    w_matchMask = '0;
    w_freeMask  = '0;
    w_relMask   = '0;
    w_matchIdx  = '0;
    w_freeIdx   = '0;
    w_relIdx    = '0;
    w_actIdx    = '0;
    w_relBest   = '0;
    w_actBest   = '0;
    w_relFound  = 1'b0;
    w_actFound  = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_matchMask[i] = (r_vState[i] == V_ACTIVE) && (r_vPitch[i] == r_pitch);
      w_freeMask[i]  = (r_vState[i] == V_FREE);
      w_relMask[i]   = (r_vState[i] == V_REL);
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (w_matchMask[i]) w_matchIdx = IDX_W'(i);
      if (w_freeMask[i])  w_freeIdx  = IDX_W'(i);
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_relMask[i] && (!w_relFound || r_vRank[i] > w_relBest)) begin
        w_relFound = 1'b1;
        w_relBest  = r_vRank[i];
        w_relIdx   = IDX_W'(i);
      end
      if ((r_vState[i] == V_ACTIVE) && (!w_actFound || r_vRank[i] > w_actBest)) begin
        w_actFound = 1'b1;
        w_actBest  = r_vRank[i];
        w_actIdx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge AUD_BCLK or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      r_matchMask <= '0;
      r_freeMask  <= '0;
      r_relMask   <= '0;
      r_matchIdx  <= '0;
      r_freeIdx   <= '0;
      r_relIdx    <= '0;
      r_actIdx    <= '0;
    end else if (r_state == S_SEARCH) begin
      r_matchMask <= w_matchMask;
      r_freeMask  <= w_freeMask;
      r_relMask   <= w_relMask;
      r_matchIdx  <= w_matchIdx;
      r_freeIdx   <= w_freeIdx;
      r_relIdx    <= w_relIdx;
      r_actIdx    <= w_actIdx;
    end
  end

  // Release countdown runs first so that a COMMIT write overrides it.
  always_comb begin
    w_vStateNext = r_vState;
    w_vPitchNext = r_vPitch;
    w_vCntNext   = r_vCnt;
    w_vRankNext  = r_vRank;
    w_trigNext   = '0;
    w_stealNext  = 1'b0;
    w_stealCand  = 1'b0;
    w_target     = r_actIdx;
    if (|r_matchMask)     w_target = r_matchIdx;
    else if (|r_freeMask) w_target = r_freeIdx;
    else if (|r_relMask)  w_target = r_relIdx;
    else                  w_stealCand = 1'b1;

    for (int i = 0; i < NUM_VOICES; i++) begin
      if (sample_tick && r_vState[i] == V_REL) begin
        w_vCntNext[i] = r_vCnt[i] - REL_W'(1);
        if (r_vCnt[i] == REL_W'(1)) w_vStateNext[i] = V_FREE;
      end
    end

    if (r_state == S_COMMIT) begin
      if (r_play) begin
        w_stealNext = w_stealCand;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IDX_W'(i) == w_target) begin
            w_vStateNext[i] = V_ACTIVE;
            w_vPitchNext[i] = r_pitch;
            w_vCntNext[i]   = '0;
            w_vRankNext[i]  = '0;
            w_trigNext[i]   = 1'b1;
          end else if (r_vRank[i] < r_vRank[w_target]) begin
            w_vRankNext[i] = r_vRank[i] + IDX_W'(1);
          end
        end
      end else begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (r_matchMask[i]) begin
            if (r_relLen != '0) begin
              w_vStateNext[i] = V_REL;
              w_vCntNext[i]   = r_relLen;
            end else begin
              w_vStateNext[i] = V_FREE;
              w_vCntNext[i]   = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge AUD_BCLK or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vState[i] <= V_FREE;
        r_vPitch[i] <= '0;
        r_vCnt[i]   <= '0;
        r_vRank[i]  <= IDX_W'(i);
      end
      r_gate  <= '0;
      r_busy  <= '0;
      r_trig  <= '0;
      r_steal <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vState[i] <= w_vStateNext[i];
        r_vPitch[i] <= w_vPitchNext[i];
        r_vCnt[i]   <= w_vCntNext[i];
        r_vRank[i]  <= w_vRankNext[i];
        r_gate[i]   <= (w_vStateNext[i] == V_ACTIVE);
        r_busy[i]   <= (w_vStateNext[i] != V_FREE);
      end
      r_trig  <= w_trigNext;
      r_steal <= w_stealNext;
    end
  end

  always_comb begin
    voice_pitch = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_pitch[7*i +: 7] = r_vPitch[i];
  end

  assign voice_gate  = r_gate;
  assign voice_busy  = r_busy;
  assign voice_trig  = r_trig;
  assign steal_pulse = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus randomized
// commands compared against a slot/LRU-list reference model.
module tb_voice_allocator;

  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_play = 1'b0;
  logic [6:0]    cmd_pitch = '0;
  logic [15:0]   release_len = '0;
  logic [NV-1:0] voice_gate, voice_busy, voice_trig;
  logic [7*NV-1:0] voice_pitch;
  logic          steal_pulse;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = free, 1 = active, 2 = releasing; lru[0] is newest.
  int         mState [NV];
  logic [6:0] mPitch [NV];
  int         mCnt [NV];
  int         lru [$];

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .AUD_BCLK(clk), .AUD_DACLRCK(rst), .sample_tick(sample_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_play(cmd_play),
    .cmd_pitch(cmd_pitch), .release_len(release_len),
    .voice_gate(voice_gate), .voice_busy(voice_busy), .voice_pitch(voice_pitch),
    .voice_trig(voice_trig), .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    lru.delete();
    for (int i = 0; i < NV; i++) begin
      mState[i] = 0;
      mPitch[i] = '0;
      mCnt[i]   = 0;
      lru.push_back(i);
    end
  endtask

  task automatic modelNoteOn(input logic [6:0] p, output int tgt, output bit st);
    int pos;
    tgt = -1;
    st  = 1'b0;
    for (int i = 0; i < NV; i++) if (tgt < 0 && mState[i] == 1 && mPitch[i] == p) tgt = i;
    for (int i = 0; i < NV; i++) if (tgt < 0 && mState[i] == 0) tgt = i;
    for (int k = lru.size() - 1; k >= 0; k--) if (tgt < 0 && mState[lru[k]] == 2) tgt = lru[k];
    if (tgt < 0) begin
      tgt = lru[lru.size() - 1];
      st  = 1'b1;
    end
    mState[tgt] = 1;
    mPitch[tgt] = p;
    mCnt[tgt]   = 0;
    pos = 0;
    for (int k = 0; k < lru.size(); k++) if (lru[k] == tgt) pos = k;
    lru.delete(pos);
    lru.push_front(tgt);
  endtask

  task automatic modelNoteOff(input logic [6:0] p, input int rel);
    for (int i = 0; i < NV; i++) begin
      if (mState[i] == 1 && mPitch[i] == p) begin
        mState[i] = (rel != 0) ? 2 : 0;
        mCnt[i]   = rel;
      end
    end
  endtask

  task automatic modelTick();
    for (int i = 0; i < NV; i++) begin
      if (mState[i] == 2) begin
        mCnt[i]--;
        if (mCnt[i] == 0) mState[i] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [NV-1:0] expTrig, input logic expSteal);
    logic [NV-1:0]   eg, eb;
    logic [7*NV-1:0] ep;
    for (int i = 0; i < NV; i++) begin
      eg[i] = (mState[i] == 1);
      eb[i] = (mState[i] != 0);
      ep[7*i +: 7] = mPitch[i];
    end
    checkVal({tag, ":gate"},  voice_gate,  eg);
    checkVal({tag, ":busy"},  voice_busy,  eb);
    checkVal({tag, ":pitch"}, voice_pitch, ep);
    checkVal({tag, ":trig"},  voice_trig,  expTrig);
    checkVal({tag, ":steal"}, steal_pulse, expSteal);
    checkVal({tag, ":ready"}, cmd_ready,   1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // One command through IDLE/SEARCH/COMMIT, checked on the pulse cycle and after.
  task automatic applyStimulus(input logic play, input logic [6:0] p, input int rel, input string tag);
    int  tgt;
    bit  st;
    logic [NV-1:0] et;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int w = 0; w < 8 && cmd_ready !== 1'b1; w++) @(negedge clk);
    checkVal({tag, ":ready_wait"}, cmd_ready, 1'b1);
    cmd_valid   = 1'b1;
    cmd_play    = play;
    cmd_pitch   = p;
    release_len = 16'(rel);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkVal({tag, ":ready_search"}, cmd_ready, 1'b0);
    @(negedge clk);
    checkVal({tag, ":ready_commit"}, cmd_ready, 1'b0);
    @(negedge clk);
    et = '0;
    st = 1'b0;
    if (play) begin
      modelNoteOn(p, tgt, st);
      et = NV'(1) << tgt;
    end else begin
      modelNoteOff(p, rel);
    end
    checkOutput(tag, et, st);
    @(negedge clk);
    checkOutput({tag, ":post"}, '0, 1'b0);
  endtask

  // mode 0: no ticks, 1: tick every cycle, 2: random ticks.
  task automatic idleCycles(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      sample_tick = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      if (sample_tick) modelTick();
    end
    @(negedge clk);
    sample_tick = 1'b0;
    checkOutput("idle", '0, 1'b0);
  endtask

  initial begin
    logic [6:0] bp [3];
    int  t;
    bit  s;
    bp = '{7'd60, 7'd62, 7'd64};
    modelReset();

    // Reset while a note-on sits in SEARCH: the command must vanish.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_play  = 1'b1;
    cmd_pitch = 7'd60;
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("rst_mid", '0, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid_1", '0, 1'b0);
    @(negedge clk);
    checkOutput("rst_mid_2", '0, 1'b0);

    // Back-to-back note-ons with cmd_valid held high.
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_play    = 1'b1;
    release_len = '0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      checkVal("b2b_ready", cmd_ready, 1'(k % 3 == 0));
      if (k % 3 == 0) begin
        if (k > 0) begin
          modelNoteOn(bp[k/3-1], t, s);
          checkOutput("b2b", NV'(1) << t, s);
        end
        cmd_pitch = bp[k/3];
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    modelNoteOn(bp[2], t, s);
    checkOutput("b2b_last", NV'(1) << t, s);
    checkVal("b2b_gate", voice_gate, 8'b0000_0111);
    @(negedge clk);
    checkOutput("b2b_post", '0, 1'b0);

    applyStimulus(1'b1, 7'd60, 0, "retrig60");
    checkVal("retrig60_gate", voice_gate, 8'b0000_0111);

    // Full bank, one voice releasing: it is reused before any steal.
    doReset();
    for (int p = 60; p < 68; p++) applyStimulus(1'b1, 7'(p), 0, "fill");
    applyStimulus(1'b0, 7'd63, 3, "off63");
    applyStimulus(1'b1, 7'd70, 0, "reuse_rel");
    checkVal("reuse_rel_pitch3", voice_pitch[27:21], 7'd70);

    // Full bank, all active: the oldest voice is stolen.
    doReset();
    for (int p = 60; p < 68; p++) applyStimulus(1'b1, 7'(p), 0, "fill2");
    applyStimulus(1'b1, 7'd80, 0, "steal80");
    checkVal("steal80_pitch0", voice_pitch[6:0], 7'd80);

    // Release tail timing.
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, bp[k], 0, "rel_fill");
    applyStimulus(1'b0, 7'd62, 2, "off62");
    checkVal("off62_gate1", voice_gate[1], 1'b0);
    checkVal("off62_busy1", voice_busy[1], 1'b1);
    idleCycles(1, 1);
    checkVal("tick1_busy1", voice_busy[1], 1'b1);
    idleCycles(1, 1);
    checkVal("tick2_busy1", voice_busy[1], 1'b0);
    applyStimulus(1'b1, 7'd62, 0, "on62");
    applyStimulus(1'b0, 7'd62, 0, "off62_zero");
    checkVal("off62_zero_busy1", voice_busy[1], 1'b0);
    applyStimulus(1'b0, 7'd99, 5, "off99");
    applyStimulus(1'b1, 7'd0, 0, "on0");
    applyStimulus(1'b0, 7'd0, 1, "off0");
    idleCycles(2, 1);

    // Randomized commands with random idle gaps and ticks.
    for (int n = 0; n < 80; n++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 7'($urandom_range(60, 75)),
                    int'($urandom_range(0, 4)), "rand");
      idleCycles(int'($urandom_range(0, 5)), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
